// File: rtl/seq_alu.sv
// Multi-cycle unsigned add/sub/mul/div unit with valid/ready handshakes on both sides.
// Mul is shift-add LSB-first, div is restoring MSB-first; both take WIDTH iterations.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               error
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_DONE} state_t;

  state_t                 state, state_nx;
  logic [1:0]             op_p0;
  logic [WIDTH-1:0]       a_p0, b_p0;
  logic [2*WIDTH-1:0]     acc_p0, mcand_p0, acc_nx;
  logic [WIDTH-1:0]       mplier_p0, rem_p0, quo_p0;
  logic [2*WIDTH-1:0]     div_nx;
  logic [CW-1:0]          cnt_p0;
  logic                   div_zero, quick;

  // Single-cycle results: add, sub, and the zero result of divide-by-zero.
  function automatic logic [2*WIDTH-1:0] quick_result(input logic [1:0] f_op,
                                                      input logic [WIDTH-1:0] f_a,
                                                      input logic [WIDTH-1:0] f_b);
    logic [2*WIDTH-1:0] xa, xb;
    xa = {{WIDTH{1'b0}}, f_a};
    xb = {{WIDTH{1'b0}}, f_b};
    case (f_op)
      2'b00:   quick_result = xa + xb;
      2'b01:   quick_result = xa - xb;
      default: quick_result = '0;
    endcase
  endfunction

  // One restoring-division step; returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] f_rem,
                                                  input logic [WIDTH-1:0] f_quo,
                                                  input logic [WIDTH-1:0] f_div);
    logic [WIDTH:0] sh, diff;
    sh   = {f_rem, f_quo[WIDTH-1]};
    diff = sh - {1'b0, f_div};
    if (!diff[WIDTH]) div_step = {diff[WIDTH-1:0], f_quo[WIDTH-2:0], 1'b1};
    else              div_step = {sh[WIDTH-1:0],   f_quo[WIDTH-2:0], 1'b0};
  endfunction

  assign div_zero = (op_p0 == 2'b11) && (b_p0 == '0);
  assign quick    = !op_p0[1] || div_zero;
  assign acc_nx   = mplier_p0[0] ? acc_p0 + mcand_p0 : acc_p0;
  assign div_nx   = div_step(rem_p0, quo_p0, b_p0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid)          state_nx = S_LOAD;
      S_LOAD:                        state_nx = quick ? S_DONE : S_BUSY;
      S_BUSY: if (cnt_p0 == LAST)    state_nx = S_DONE;
      S_DONE: if (out_ready)         state_nx = S_IDLE;
      default:                       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      acc_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      rem_p0    <= '0;
      quo_p0    <= '0;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        // Stage p0: latch the operation and seed both iterative datapaths.
        S_IDLE: if (in_valid) begin
          op_p0     <= op;
          a_p0      <= a;
          b_p0      <= b;
          acc_p0    <= '0;
          mcand_p0  <= {{WIDTH{1'b0}}, a};
          mplier_p0 <= b;
          rem_p0    <= '0;
          quo_p0    <= a;
          cnt_p0    <= '0;
        end
        S_LOAD: begin
          cnt_p0 <= '0;
          if (quick) begin
            out_valid <= 1'b1;
            error     <= div_zero;
            result    <= quick_result(op_p0, a_p0, b_p0);
          end
        end
        S_BUSY: begin
          acc_p0    <= acc_nx;
          mcand_p0  <= mcand_p0 << 1;
          mplier_p0 <= mplier_p0 >> 1;
          rem_p0    <= div_nx[2*WIDTH-1:WIDTH];
          quo_p0    <= div_nx[WIDTH-1:0];
          cnt_p0    <= cnt_p0 + CW'(1);
          if (cnt_p0 == LAST) begin
            out_valid <= 1'b1;
            error     <= 1'b0;
            result    <= op_p0[0] ? div_nx : acc_nx;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          error     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): vector table plus backpressure and mid-op reset sequences.
module tb_seq_alu;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, error;
  logic [W-1:0]   a, b;
  logic [1:0]     op;
  logic [2*W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    int          lat;
    logic [15:0] res;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[12];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Presents one op, waits (bounded) for out_valid, checks latency and outputs,
  // then completes the handshake if out_ready is high.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop,
                        input int lat, input logic [15:0] res, input logic err, input string nm);
    int cyc;
    int rdy_hi;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    cyc = 0; rdy_hi = 0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(lat));
    chk({nm, " in_ready_busy"}, 32'(rdy_hi), 32'd0);
    chk({nm, " result"}, 32'(result), 32'(res));
    chk({nm, " error"}, 32'(error), 32'(err));
    if (out_ready) begin
      @(posedge clk); #1;
      chk({nm, " out_valid_drop"}, 32'(out_valid), 32'd0);
      chk({nm, " error_drop"}, 32'(error), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{8'd200, 8'd100, 2'b00, 1, 16'h012C, 1'b0, "add_200_100"};
    vecs[1]  = '{8'd5,   8'd10,  2'b01, 1, 16'hFFFB, 1'b0, "sub_wrap"};
    vecs[2]  = '{8'd255, 8'd255, 2'b10, 9, 16'hFE01, 1'b0, "mul_255_255"};
    vecs[3]  = '{8'd0,   8'd77,  2'b10, 9, 16'h0000, 1'b0, "mul_0_77"};
    vecs[4]  = '{8'd200, 8'd7,   2'b11, 9, 16'h041C, 1'b0, "div_200_7"};
    vecs[5]  = '{8'd7,   8'd200, 2'b11, 9, 16'h0700, 1'b0, "div_7_200"};
    vecs[6]  = '{8'd123, 8'd0,   2'b11, 1, 16'h0000, 1'b1, "div_by_zero"};
    vecs[7]  = '{8'd1,   8'd1,   2'b00, 1, 16'h0002, 1'b0, "add_after_dz"};
    vecs[8]  = '{8'd255, 8'd255, 2'b00, 1, 16'h01FE, 1'b0, "add_carry"};
    vecs[9]  = '{8'd10,  8'd5,   2'b01, 1, 16'h0005, 1'b0, "sub_pos"};
    vecs[10] = '{8'd13,  8'd11,  2'b10, 9, 16'h008F, 1'b0, "mul_13_11"};
    vecs[11] = '{8'd255, 8'd1,   2'b11, 9, 16'h00FF, 1'b0, "div_255_1"};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    chk("out_valid_in_reset", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_error", 32'(error), 32'd0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lat, vecs[i].res, vecs[i].err, vecs[i].name);

    // Backpressure: result must hold while out_ready is low; in_valid meanwhile is ignored.
    out_ready = 1'b0;
    run_op(8'd200, 8'd7, 2'b11, 9, 16'h041C, 1'b0, "div_bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'd1; b = 8'd1; op = 2'b00;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'h041C);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);

    // Reset while the multiply sits at count 4.
    a = 8'd255; b = 8'd255; op = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    chk("rst_mid_result", 32'(result), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("rst_mid_no_result", 32'(seen), 32'd0);
    end
    run_op(8'd9, 8'd2, 2'b11, 9, 16'h0104, 1'b0, "div_9_2_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
